pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Parametrised lock-supervision and reset-sequencing block that sits beside the video/GPU PLL wrapper, in the PLL reference-clock domain.
- Drives the PLL reset and monitors its asynchronous locked output.
- After lock has been stable for a programmable time, releases NUM_CHAN downstream domain resets in staggered order (pixel, 65/130 MHz core, slow peripheral, ...).
- On lock loss, timeout or software request, collapses all domains and retries automatically, counting relock events.

Parameters:
- NUM_CHAN, 4: number of downstream reset channels (1..16).
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 500000: max cycles in WAIT_LOCK before retrying the PLL reset (>=2).
- LOCK_STABLE, 1024: consecutive synchronised-locked cycles required before release (>=1).
- STAGGER, 64: cycles between successive channel releases (>=1).
- CNT_W, 20: internal counter width; must hold max(LOCK_TIMEOUT, LOCK_STABLE, PLL_RST_CYCLES, STAGGER).

Ports:
- refclk, in, 1: single clock, PLL reference clock.
- rst_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL locked output. Asynchronous; passed through a 2-flop synchroniser to form lock_s.
- sw_reset_req, in, 1: synchronous one-cycle pulse requesting a full re-sequence.
- pll_rst, out, 1: active-high reset to the PLL.
- chan_rst_n, out, NUM_CHAN: active-low per-domain resets; bit 0 is released first.
- all_ready, out, 1: high only in RUN.
- state, out, 3: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- relock_count, out, 8: saturating count of lock losses and timeouts.

Behaviour:
- Outputs are registered.
- Reset values: state=PLL_RST, pll_rst=1, chan_rst_n=all 0, all_ready=0, relock_count=0, synchroniser flops=0, counters=0.
- PLL_RST:
  - pll_rst=1, chan_rst_n=0.
  - Counter counts PLL_RST_CYCLES cycles, then state goes to WAIT_LOCK and pll_rst=0 on the same edge.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE with the counter loaded to 1.
  - After LOCK_TIMEOUT cycles without lock_s, goes to PLL_RST and relock_count increments.
- STABLE:
  - Counter increments while lock_s=1.
  - Counter reaching LOCK_STABLE goes to RELEASE.
  - lock_s=0 goes to WAIT_LOCK with the timeout counter cleared; relock_count is not incremented.
- RELEASE:
  - chan_rst_n[0] goes high on the edge entering RELEASE.
  - chan_rst_n[k] goes high STAGGER cycles after chan_rst_n[k-1].
  - Released bits stay high.
  - STAGGER cycles after the last bit is released, goes to RUN and all_ready=1.
  - With NUM_CHAN=1, goes to RUN STAGGER cycles after entry.
- RUN: holds indefinitely while lock_s=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge: chan_rst_n=all 0, all_ready=0, pll_rst=1, state=PLL_RST.
  - relock_count increments.
- sw_reset_req=1 in any state except PLL_RST: same as lock loss, but relock_count is unchanged. Ignored in PLL_RST.
- Simultaneous lock loss and sw_reset_req: counts as lock loss (relock_count increments once).
- relock_count saturates at 255 and clears only on rst_n.
- Latency:
  - pll_locked to lock_s is 2 edges.
  - Lock loss to chan_rst_n low is at most 3 edges after the pll_locked fall.
- rst_n assertion mid-sequence immediately forces all reset values asynchronously.
- Deassertion of rst_n is assumed synchronised externally.
- Glitch rule: a lock_s drop of any length in STABLE restarts the stability count (no filtering beyond the synchroniser).

Test Plan:
(Params for T1–T5: NUM_CHAN=4, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=3.)
- T1 nominal:
  - Stimulus: release rst_n, raise pll_locked 10 cycles later.
  - Required: pll_rst high for 4 cycles; state goes 1 then 2; RELEASE entered 8 cycles after lock_s rises.
  - Required: chan_rst_n = 0001, 0011, 0111, 1111 at 3-cycle spacing; all_ready 3 cycles after 1111; relock_count=0.
- T2 timeout:
  - Stimulus: hold pll_locked=0.
  - Required: pll_rst re-asserts every 4+32 cycles; relock_count increments each retry and saturates at 255 after 255 retries.
- T3 stability glitch:
  - Stimulus: drop pll_locked for 1 cycle after 5 locked cycles in STABLE.
  - Required: return to WAIT_LOCK, stability count restarts, relock_count unchanged, all chan_rst_n remain 0.
- T4 lock loss in RUN:
  - Stimulus: drop pll_locked while in RUN.
  - Required: within 3 edges chan_rst_n=0000, all_ready=0, pll_rst=1, relock_count=1; full re-sequence completes after lock returns.
- T5 sw_reset_req:
  - Stimulus: pulse sw_reset_req in RELEASE after chan_rst_n=0011.
  - Required: next edge chan_rst_n=0000, state=0, relock_count unchanged.
  - Stimulus: pulse it in PLL_RST. Required: no effect.
- T6 async reset:
  - Stimulus: assert rst_n mid-RELEASE, off a clock edge.
  - Required: all outputs take reset values before the next refclk edge.
  - Repeat T1 with NUM_CHAN=1; required: all_ready 3 cycles after chan_rst_n=1.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervision and staggered downstream reset release.
// Holds the PLL in reset, waits for a stable lock, then releases NUM_CHAN
// domain resets one at a time. Lock loss, a lock timeout or a software
// request collapses every domain and restarts the sequence.
module pll_reset_sequencer #(
    parameter int unsigned NUM_CHAN       = 4,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 500000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned STAGGER        = 64,
    parameter int unsigned CNT_W          = 20
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                sw_reset_req,
    output logic                pll_rst,
    output logic [NUM_CHAN-1:0] chan_rst_n,
    output logic                all_ready,
    output logic [2:0]          state,
    output logic [7:0]          relock_count
);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0]    RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]    StaggerLast = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]    CntOne      = CNT_W'(1);
    localparam logic [NUM_CHAN-1:0] ChanOne     = NUM_CHAN'(1);

    logic [1:0]          sync_q;
    logic                lock_s;
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pll_rst_q;
    logic [NUM_CHAN-1:0] chan_q;
    logic                ready_q;
    logic [7:0]          relock_q;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lock_s = sync_q[1];

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            chan_q    <= '0;
            ready_q   <= 1'b0;
            relock_q  <= 8'd0;
        end else begin
            case (state_q)
                StPllRst: begin
                    // Software requests are ignored while already in reset.
                    if (cnt_q == RstLast) begin
                        state_q   <= StWaitLock;
                        pll_rst_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StWaitLock: begin
                    if (!lock_s && cnt_q == TimeoutLast) begin
                        // Timeout is a counted relock event even alongside a sw request.
                        state_q   <= StPllRst;
                        pll_rst_q <= 1'b1;
                        cnt_q     <= '0;
                        if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                    end else if (sw_reset_req) begin
                        state_q   <= StPllRst;
                        pll_rst_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (lock_s) begin
                        state_q <= StStable;
                        cnt_q   <= CntOne;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StStable: begin
                    if (sw_reset_req) begin
                        state_q   <= StPllRst;
                        pll_rst_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (!lock_s) begin
                        // Any dropout restarts the stability window; not a relock.
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q >= StableLast) begin
                        state_q <= StRelease;
                        chan_q  <= ChanOne;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StRelease: begin
                    if (!lock_s || sw_reset_req) begin
                        state_q   <= StPllRst;
                        pll_rst_q <= 1'b1;
                        chan_q    <= '0;
                        ready_q   <= 1'b0;
                        cnt_q     <= '0;
                        if (!lock_s && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                    end else if (cnt_q == StaggerLast) begin
                        cnt_q <= '0;
                        if (&chan_q) begin
                            state_q <= StRun;
                            ready_q <= 1'b1;
                        end else begin
                            // Release the next channel in ascending bit order.
                            chan_q <= (chan_q << 1) | ChanOne;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StRun: begin
                    if (!lock_s || sw_reset_req) begin
                        state_q   <= StPllRst;
                        pll_rst_q <= 1'b1;
                        chan_q    <= '0;
                        ready_q   <= 1'b0;
                        cnt_q     <= '0;
                        if (!lock_s && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= StPllRst;
                    pll_rst_q <= 1'b1;
                    chan_q    <= '0;
                    ready_q   <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign pll_rst      = pll_rst_q;
    assign chan_rst_n   = chan_q;
    assign all_ready    = ready_q;
    assign state        = state_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a cycle-stamped vector table for the
// nominal, lock-loss, software-reset and glitch sequences, then hand-written
// sequences for async reset, lock timeout saturation and a single channel.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic [3:0] chan_rst_n;
    logic       all_ready;
    logic [2:0] state;
    logic [7:0] relock_count;

    logic       rst1_n;
    logic       locked1;
    logic       sw1;
    logic       pll_rst1;
    logic [0:0] chan1;
    logic       ready1;
    logic [2:0] state1;
    logic [7:0] rc1;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .NUM_CHAN(4), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8), .STAGGER(3),
        .CNT_W(20)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
        .pll_rst(pll_rst), .chan_rst_n(chan_rst_n), .all_ready(all_ready), .state(state),
        .relock_count(relock_count)
    );

    pll_reset_sequencer #(
        .NUM_CHAN(1), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8), .STAGGER(3),
        .CNT_W(20)
    ) dut1 (
        .refclk(refclk), .rst_n(rst1_n), .pll_locked(locked1), .sw_reset_req(sw1),
        .pll_rst(pll_rst1), .chan_rst_n(chan1), .all_ready(ready1), .state(state1),
        .relock_count(rc1)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        int         wait_n;
        logic       locked;
        logic       sw;
        logic       exp_pll_rst;
        logic [2:0] exp_state;
        logic [3:0] exp_chan;
        logic       exp_ready;
        logic [7:0] exp_rc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int w, input logic l, input logic s, input logic p,
                       input logic [2:0] st, input logic [3:0] ch, input logic r,
                       input logic [7:0] rc);
        vec_t v;
        v.wait_n = w; v.locked = l; v.sw = s; v.exp_pll_rst = p; v.exp_state = st;
        v.exp_chan = ch; v.exp_ready = r; v.exp_rc = rc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic [2:0] st,
                           input logic [3:0] ch, input logic r, input logic [7:0] rc);
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(p));
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".chan_rst_n"}, 32'(chan_rst_n), 32'(ch));
        chk({tag, ".all_ready"}, 32'(all_ready), 32'(r));
        chk({tag, ".relock_count"}, 32'(relock_count), 32'(rc));
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        // Edge numbers below count from the rst_n release (edge 0).
        // T1 nominal: lock raised after edge 10, lock_s at 12, RELEASE at 20.
        add(3, 0, 0, 1, 0, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 1, 4'b0000, 0, 0);
        add(6, 0, 0, 0, 1, 4'b0000, 0, 0);
        add(2, 1, 0, 0, 1, 4'b0000, 0, 0);
        add(1, 1, 0, 0, 2, 4'b0000, 0, 0);
        add(6, 1, 0, 0, 2, 4'b0000, 0, 0);
        add(1, 1, 0, 0, 3, 4'b0001, 0, 0);
        add(2, 1, 0, 0, 3, 4'b0001, 0, 0);
        add(1, 1, 0, 0, 3, 4'b0011, 0, 0);
        add(3, 1, 0, 0, 3, 4'b0111, 0, 0);
        add(3, 1, 0, 0, 3, 4'b1111, 0, 0);
        add(2, 1, 0, 0, 3, 4'b1111, 0, 0);
        add(1, 1, 0, 0, 4, 4'b1111, 1, 0);
        add(5, 1, 0, 0, 4, 4'b1111, 1, 0);
        // T4 lock loss in RUN after edge 37: collapse on the third edge.
        add(2, 0, 0, 0, 4, 4'b1111, 1, 0);
        add(1, 0, 0, 1, 0, 4'b0000, 0, 1);
        add(4, 1, 0, 0, 1, 4'b0000, 0, 1);
        add(1, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(7, 1, 0, 0, 3, 4'b0001, 0, 1);
        add(12, 1, 0, 0, 4, 4'b1111, 1, 1);
        // T5 sw request in RUN, then in RELEASE at 0011, then ignored in PLL_RST.
        add(1, 1, 1, 1, 0, 4'b0000, 0, 1);
        add(4, 1, 0, 0, 1, 4'b0000, 0, 1);
        add(1, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(7, 1, 0, 0, 3, 4'b0001, 0, 1);
        add(3, 1, 0, 0, 3, 4'b0011, 0, 1);
        add(1, 1, 1, 1, 0, 4'b0000, 0, 1);
        add(1, 1, 1, 1, 0, 4'b0000, 0, 1);
        add(2, 1, 0, 1, 0, 4'b0000, 0, 1);
        add(1, 1, 0, 0, 1, 4'b0000, 0, 1);
        // T3 one-cycle dropout after 5 stable cycles; would have released at edge 93.
        add(5, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(1, 0, 0, 0, 2, 4'b0000, 0, 1);
        add(2, 1, 0, 0, 1, 4'b0000, 0, 1);
        add(1, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(6, 1, 0, 0, 2, 4'b0000, 0, 1);
        add(1, 1, 0, 0, 3, 4'b0001, 0, 1);
        add(3, 1, 0, 0, 3, 4'b0011, 0, 1);

        rst_n = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0;
        rst1_n = 1'b0; locked1 = 1'b0; sw1 = 1'b0;
        step(3);
        chk_all("reset", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            pll_locked   = vecs[i].locked;
            sw_reset_req = vecs[i].sw;
            step(vecs[i].wait_n);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_pll_rst, vecs[i].exp_state,
                    vecs[i].exp_chan, vecs[i].exp_ready, vecs[i].exp_rc);
        end

        // T6 async reset mid-RELEASE, away from the clock edge.
        sw_reset_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd0);

        // T2 lock timeout: retry period 36, saturating relock_count.
        pll_locked = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(35);
        chk_all("to_wait", 1'b0, 3'd1, 4'b0000, 1'b0, 8'd0);
        step(1);
        chk_all("to_retry1", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd1);
        step(4);
        chk_all("to_wait2", 1'b0, 3'd1, 4'b0000, 1'b0, 8'd1);
        step(32);
        chk_all("to_retry2", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd2);
        step(9179 - 72);
        chk_all("to_254", 1'b0, 3'd1, 4'b0000, 1'b0, 8'd254);
        step(1);
        chk_all("to_255", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd255);
        step(36);
        chk_all("to_sat", 1'b1, 3'd0, 4'b0000, 1'b0, 8'd255);

        // NUM_CHAN=1 nominal: RELEASE at edge 20, RUN at edge 23.
        rst1_n = 1'b1;
        step(10);
        locked1 = 1'b1;
        step(9);
        chk("n1_stable.state", 32'(state1), 32'd2);
        chk("n1_stable.chan", 32'(chan1), 32'd0);
        step(1);
        chk("n1_rel.state", 32'(state1), 32'd3);
        chk("n1_rel.chan", 32'(chan1), 32'd1);
        chk("n1_rel.ready", 32'(ready1), 32'd0);
        step(2);
        chk("n1_rel2.ready", 32'(ready1), 32'd0);
        step(1);
        chk("n1_run.state", 32'(state1), 32'd4);
        chk("n1_run.ready", 32'(ready1), 32'd1);
        chk("n1_run.pll_rst", 32'(pll_rst1), 32'd0);
        chk("n1_run.rc", 32'(rc1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
